// File: rtl/encoder_8to3.sv
// -----------------------------------------------------------------------------
// encoder_8to3
//
// Registered 8-to-3 encoder with a multi-hot error detector and a saturating
// error counter.
//
// Parameters
//   PRIORITY : 1 = highest set bit wins, 0 = bitwise OR of all set-bit indices
//   CNT_W    : width of the error counter
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset, has priority over en
//   en         in   sample enable
//   Data_In    in   [7:0] request vector, bit i requests code i
//   Data_Out   out  [2:0] registered binary code
//   valid      out  Data_Out holds a fresh code for a non-zero input
//   onehot_err out  last sampled input had two or more bits set
//   err_cnt    out  [CNT_W-1:0] saturating count of multi-hot samples
//
// All outputs come straight from flip-flops. Latency is one clock.
// -----------------------------------------------------------------------------
module encoder_8to3 #(
  parameter int PRIORITY = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       Data_In,
  output logic [2:0]       Data_Out,
  output logic             valid,
  output logic             onehot_err,
  output logic [CNT_W-1:0] err_cnt
);

  // ---------------------------------------------------------------------------
  // Combinational encode of the current input
  // ---------------------------------------------------------------------------
  logic       any_set;
  logic       multi_set;
  logic [2:0] pri_code;
  logic [2:0] or_code;
  logic [2:0] enc_code;

  assign any_set = |Data_In;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_set = |(Data_In & (Data_In - 8'd1));

  // Priority encode as a halving tree: each level picks the upper half if it
  // holds any request, and that choice is the next code bit (MSB first).
  logic [3:0] pri_nibble;
  logic [1:0] pri_pair;

  assign pri_code[2] = |Data_In[7:4];
  assign pri_nibble  = pri_code[2] ? Data_In[7:4] : Data_In[3:0];
  assign pri_code[1] = |pri_nibble[3:2];
  assign pri_pair    = pri_code[1] ? pri_nibble[3:2] : pri_nibble[1:0];
  assign pri_code[0] = pri_pair[1];

  // OR-encode: code bit b is set when any request whose index has bit b set
  // is active. Masks are elaborated per bit position.
  logic [7:0] or_terms [3];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_or_bit
      for (gj = 0; gj < 8; gj++) begin : g_or_src
        if (((gj >> gi) & 1) == 1) begin : g_take
          assign or_terms[gi][gj] = Data_In[gj];
        end else begin : g_skip
          assign or_terms[gi][gj] = 1'b0;
        end
      end
      assign or_code[gi] = |or_terms[gi];
    end
  endgenerate

  // Both encoders reduce to 000 for an all-zero input, but gating on any_set
  // keeps the idle code explicit regardless of encoder choice.
  assign enc_code = !any_set        ? 3'b000   :
                    (PRIORITY != 0) ? pri_code : or_code;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       data_q,  data_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;       // valid only marks a freshly sampled code
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (en) begin
      data_d  = enc_code;
      valid_d = any_set;
      err_d   = multi_set;
      if (multi_set && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers; reset wins over en and drops any pending sample.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= 3'b000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Data_Out   = data_q;
  assign valid      = valid_q;
  assign onehot_err = err_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// -----------------------------------------------------------------------------
// tb_encoder_8to3
//
// Three encoder instances share one stimulus stream: priority (CNT_W=8),
// OR-encoding (CNT_W=8) and priority with a 2-bit counter. A reference model
// predicts each clock's outputs and pushes them into a queue; a monitor on the
// falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [2:0] out_pri, out_or, out_sat;
  logic       v_pri, v_or, v_sat;
  logic       e_pri, e_or, e_sat;
  logic [7:0] c_pri, c_or;
  logic [1:0] c_sat;

  always #5 clk = ~clk;

  encoder_8to3 #(.PRIORITY(1), .CNT_W(8)) u_pri (
    .clk(clk), .rst_n(rst_n), .en(en), .Data_In(din),
    .Data_Out(out_pri), .valid(v_pri), .onehot_err(e_pri), .err_cnt(c_pri));

  encoder_8to3 #(.PRIORITY(0), .CNT_W(8)) u_or (
    .clk(clk), .rst_n(rst_n), .en(en), .Data_In(din),
    .Data_Out(out_or), .valid(v_or), .onehot_err(e_or), .err_cnt(c_or));

  encoder_8to3 #(.PRIORITY(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .Data_In(din),
    .Data_Out(out_sat), .valid(v_sat), .onehot_err(e_sat), .err_cnt(c_sat));

  typedef struct {
    logic [2:0] d_pri;
    logic [2:0] d_or;
    logic       v;
    logic       e;
    int         cnt8;
    int         cnt2;
  } exp_t;

  exp_t sb[$];
  exp_t m;           // model state
  bit   have_reset = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------------------------------------------------------------------
  // Reference model, stated in terms of counts and indices
  // ---------------------------------------------------------------------------
  function automatic int count_bits(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n++;
    return n;
  endfunction

  function automatic int highest_index(input logic [7:0] d);
    int v = d;
    int idx = 0;
    while (v > 1) begin
      v = v / 2;
      idx++;
    end
    return idx;
  endfunction

  function automatic int or_of_indices(input logic [7:0] d);
    int acc = 0;
    for (int i = 0; i < 8; i++) if (d[i]) acc = acc | i;
    return acc;
  endfunction

  task automatic model(input logic r, input logic e, input logic [7:0] d);
    int n;
    if (!r) begin
      m.d_pri = 3'd0; m.d_or = 3'd0; m.v = 1'b0; m.e = 1'b0;
      m.cnt8 = 0; m.cnt2 = 0;
      have_reset = 1'b1;
    end else if (e) begin
      n = count_bits(d);
      m.v = (n >= 1);
      m.e = (n >= 2);
      m.d_pri = (n == 0) ? 3'd0 : 3'(highest_index(d));
      m.d_or  = 3'(or_of_indices(d));
      if (n >= 2) begin
        if (m.cnt8 < 255) m.cnt8++;
        if (m.cnt2 < 3)   m.cnt2++;
      end
    end else begin
      m.v = 1'b0;
    end
    if (have_reset) sb.push_back(m);
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    rst_n = r;
    en    = e;
    din   = d;
    @(posedge clk);
    model(r, e, d);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_vec++;
      if ($isunknown({out_pri, out_or, out_sat, v_pri, v_or, v_sat,
                      e_pri, e_or, e_sat, c_pri, c_or, c_sat})) begin
        n_miss++;
        $display("FAIL xcheck: outputs contain X/Z (t=%0t)", $time);
      end else begin
        chk("pri.Data_Out", int'(out_pri), int'(x.d_pri));
        chk("or.Data_Out",  int'(out_or),  int'(x.d_or));
        chk("sat.Data_Out", int'(out_sat), int'(x.d_pri));
        chk("pri.valid", int'(v_pri), int'(x.v));
        chk("or.valid",  int'(v_or),  int'(x.v));
        chk("sat.valid", int'(v_sat), int'(x.v));
        chk("pri.onehot_err", int'(e_pri), int'(x.e));
        chk("or.onehot_err",  int'(e_or),  int'(x.e));
        chk("sat.onehot_err", int'(e_sat), int'(x.e));
        chk("pri.err_cnt", int'(c_pri), x.cnt8);
        chk("or.err_cnt",  int'(c_or),  x.cnt8);
        chk("sat.err_cnt", int'(c_sat), x.cnt2);
      end
      $display("vec %0d: din=%b en=%0b rst_n=%0b pri=%b or=%b v=%0b e=%0b cnt=%0d/%0d",
               n_vec, din, en, rst_n, out_pri, out_or, v_pri, e_pri, c_pri, c_sat);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] multi_tbl [5];
    int wait_cycles;
    multi_tbl[0] = 8'b1001_0010;
    multi_tbl[1] = 8'b0000_0110;
    multi_tbl[2] = 8'b1100_0000;
    multi_tbl[3] = 8'b0000_0011;
    multi_tbl[4] = 8'b1111_1111;

    // Reset for two cycles, then one-hot walk
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(1 << i));

    // Multi-hot cases: priority vs OR encoding, counter increments
    step(1'b1, 1'b1, 8'b1001_0010);
    step(1'b1, 1'b1, 8'b0000_0110);
    step(1'b1, 1'b1, 8'b0001_0100);

    // Zero input, then en low with a pending request
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'b0010_0000);
    step(1'b1, 1'b0, 8'b0010_0000);

    // Hold check after a non-zero code: en low keeps code, drops valid
    step(1'b1, 1'b1, 8'b0110_0000);
    step(1'b1, 1'b0, 8'b0000_0001);

    // Walk interrupted by a one-cycle reset carrying a pending sample
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(1 << i));
    step(1'b0, 1'b1, 8'b1000_0001);
    for (int i = 4; i < 8; i++) step(1'b1, 1'b1, 8'(1 << i));

    // Fresh reset, then five consecutive multi-hot inputs (2-bit saturation)
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, multi_tbl[i]);

    // Randomized traffic with occasional resets and enable gaps
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)));
    end

    // Drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
